// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit:
// opcodes, FSM state encoding and Ctrl bit positions.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    localparam int B_PCOUT = 0,  B_ZLOWOUT = 1,  B_ZHIGHOUT = 2, B_MDROUT = 3,  B_LOOUT = 4;
    localparam int B_HIOUT = 5,  B_INCPC = 6,    B_READ = 7,     B_WRITE = 8;
    localparam int B_AND = 9,    B_ADD = 10,     B_SUB = 11,     B_MUL = 12,    B_DIV = 13;
    localparam int B_SHR = 14,   B_SHRA = 15,    B_SHL = 16,     B_ROR = 17,    B_ROL = 18;
    localparam int B_OR = 19,    B_NEG = 20,     B_NOT = 21;
    localparam int B_MARIN = 22, B_ZIN = 23,     B_PCIN = 24,    B_MDRIN = 25,  B_IRIN = 26;
    localparam int B_YIN = 27,   B_LOIN = 28,    B_HIIN = 29;
    localparam int B_GRA = 30,   B_GRB = 31,     B_GRC = 32,     B_RIN = 33,    B_ROUT = 34;
    localparam int B_COUT = 35,  B_BAOUT = 36,   B_CONIN = 37,   B_OUTPORTIN = 38;
    localparam int B_OUTPORTOUT = 39;

    // Final execute step of each opcode; nop, halt and undefined opcodes end at T2.
    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            OP_LD:                                         return ST_T7;
            OP_ST, OP_MUL, OP_DIV, OP_BR:                  return ST_T6;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LDI:                                return ST_T5;
            OP_NEG, OP_NOT, OP_JAL:                        return ST_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:        return ST_T3;
            default:                                       return ST_T2;
        endcase
    endfunction

    function automatic state_t step_after(input state_t s);
        case (s)
            ST_T0:   return ST_T1;
            ST_T1:   return ST_T2;
            ST_T2:   return ST_T3;
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            OP_SUB:          return B_SUB;
            OP_AND, OP_ANDI: return B_AND;
            OP_OR, OP_ORI:   return B_OR;
            OP_ROR:          return B_ROR;
            OP_ROL:          return B_ROL;
            OP_SHR:          return B_SHR;
            OP_SHRA:         return B_SHRA;
            OP_SHL:          return B_SHL;
            OP_MUL:          return B_MUL;
            OP_DIV:          return B_DIV;
            OP_NEG:          return B_NEG;
            OP_NOT:          return B_NOT;
            default:         return B_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: (state, opcode, BranchOut) -> Ctrl vector.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 40
) (
    input  state_t              state_i,
    input  logic [4:0]          opcode_i,
    input  logic                branch_i,
    output logic [CTRL_W-1:0]   ctrl_o
);

    logic is_imm;
    assign is_imm = (opcode_i == OP_ADDI) || (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_RESET, ST_HALT: ;
            ST_T0: begin ctrl_o[B_PCOUT] = 1'b1; ctrl_o[B_MARIN] = 1'b1; ctrl_o[B_INCPC] = 1'b1; ctrl_o[B_ZIN] = 1'b1; end
            ST_T1: begin ctrl_o[B_ZLOWOUT] = 1'b1; ctrl_o[B_PCIN] = 1'b1; ctrl_o[B_READ] = 1'b1; ctrl_o[B_MDRIN] = 1'b1; end
            ST_T2: begin ctrl_o[B_MDROUT] = 1'b1; ctrl_o[B_IRIN] = 1'b1; end
            default: begin
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_GRB] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_YIN] = 1'b1; end
                            ST_T4: begin
                                if (is_imm) ctrl_o[B_COUT] = 1'b1;
                                else begin ctrl_o[B_GRC] = 1'b1; ctrl_o[B_ROUT] = 1'b1; end
                                ctrl_o[alu_bit(opcode_i)] = 1'b1; ctrl_o[B_ZIN] = 1'b1;
                            end
                            ST_T5: begin ctrl_o[B_ZLOWOUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_LD, OP_LDI, OP_ST:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_GRB] = 1'b1; ctrl_o[B_BAOUT] = 1'b1; ctrl_o[B_YIN] = 1'b1; end
                            ST_T4: begin ctrl_o[B_COUT] = 1'b1; ctrl_o[B_ADD] = 1'b1; ctrl_o[B_ZIN] = 1'b1; end
                            ST_T5: begin
                                ctrl_o[B_ZLOWOUT] = 1'b1;
                                if (opcode_i == OP_LDI) begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                                else ctrl_o[B_MARIN] = 1'b1;
                            end
                            ST_T6: begin
                                if (opcode_i == OP_LD) begin ctrl_o[B_READ] = 1'b1; ctrl_o[B_MDRIN] = 1'b1; end
                                if (opcode_i == OP_ST) begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_WRITE] = 1'b1; end
                            end
                            ST_T7: if (opcode_i == OP_LD) begin ctrl_o[B_MDROUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_MUL, OP_DIV:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_YIN] = 1'b1; end
                            ST_T4: begin ctrl_o[B_GRB] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[alu_bit(opcode_i)] = 1'b1; ctrl_o[B_ZIN] = 1'b1; end
                            ST_T5: begin ctrl_o[B_ZLOWOUT] = 1'b1; ctrl_o[B_LOIN] = 1'b1; end
                            ST_T6: begin ctrl_o[B_ZHIGHOUT] = 1'b1; ctrl_o[B_HIIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_NEG, OP_NOT:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_GRB] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[alu_bit(opcode_i)] = 1'b1; ctrl_o[B_ZIN] = 1'b1; end
                            ST_T4: begin ctrl_o[B_ZLOWOUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_BR:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_CONIN] = 1'b1; end
                            ST_T4: begin ctrl_o[B_PCOUT] = 1'b1; ctrl_o[B_YIN] = 1'b1; end
                            ST_T5: begin ctrl_o[B_COUT] = 1'b1; ctrl_o[B_ADD] = 1'b1; ctrl_o[B_ZIN] = 1'b1; end
                            // Branch not taken leaves the incremented PC untouched.
                            ST_T6: if (branch_i) begin ctrl_o[B_ZLOWOUT] = 1'b1; ctrl_o[B_PCIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_JR:
                        if (state_i == ST_T3) begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_PCIN] = 1'b1; end
                    OP_JAL:
                        case (state_i)
                            ST_T3: begin ctrl_o[B_PCOUT] = 1'b1; ctrl_o[B_GRB] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                            ST_T4: begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_PCIN] = 1'b1; end
                            default: ;
                        endcase
                    OP_IN:
                        if (state_i == ST_T3) begin ctrl_o[B_OUTPORTOUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                    OP_OUT:
                        if (state_i == ST_T3) begin ctrl_o[B_GRA] = 1'b1; ctrl_o[B_ROUT] = 1'b1; ctrl_o[B_OUTPORTIN] = 1'b1; end
                    OP_MFHI:
                        if (state_i == ST_T3) begin ctrl_o[B_HIOUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                    OP_MFLO:
                        if (state_i == ST_T3) begin ctrl_o[B_LOOUT] = 1'b1; ctrl_o[B_GRA] = 1'b1; ctrl_o[B_RIN] = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini SRC hardwired control unit: instruction sequencing FSM and Run flag.
//  state   | meaning
//  RESET   | held by Clear, no strobes
//  T0-T2   | fetch
//  T3-T7   | execute, length depends on opcode
//  HALT    | stopped until Clear
module control_unit
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 40
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [31:0]         IR,
    input  logic                BranchOut,
    input  logic                Stop,
    output logic [CTRL_W-1:0]   Ctrl,
    output logic                Run
);

    state_t     state_q, state_d;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default: begin
                if (state_q == ST_T2 && opcode == OP_HALT)  state_d = ST_HALT;
                else if (state_q == last_step(opcode))      state_d = Stop ? ST_HALT : ST_T0;
                else                                        state_d = step_after(state_q);
            end
        endcase
    end

    assign Run = (state_q != ST_RESET) && (state_q != ST_HALT);

    ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .branch_i (BranchOut),
        .ctrl_o   (Ctrl)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed table, hand sequences and random instructions
// checked against a step-list model of the instruction set.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = '0;
    logic        BranchOut = 1'b0;
    logic        Stop = 1'b0;
    logic [39:0] Ctrl;
    logic        Run;

    control_unit #(.CTRL_W(40)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut),
        .Stop(Stop), .Ctrl(Ctrl), .Run(Run)
    );

    always #5 Clock = ~Clock;

    localparam logic [39:0] ONE = 40'd1;
    localparam logic [39:0] PCOUT = ONE << 0,  ZLOWOUT = ONE << 1, ZHIGHOUT = ONE << 2, MDROUT = ONE << 3;
    localparam logic [39:0] LOOUT = ONE << 4,  HIOUT = ONE << 5,   INCPC = ONE << 6,     READ = ONE << 7;
    localparam logic [39:0] WRITE = ONE << 8,  ANDm = ONE << 9,    ADDm = ONE << 10,     SUBm = ONE << 11;
    localparam logic [39:0] MULm = ONE << 12,  DIVm = ONE << 13,   SHRm = ONE << 14,     SHRAm = ONE << 15;
    localparam logic [39:0] SHLm = ONE << 16,  RORm = ONE << 17,   ROLm = ONE << 18,     ORm = ONE << 19;
    localparam logic [39:0] NEGm = ONE << 20,  NOTm = ONE << 21,   MARIN = ONE << 22,    ZIN = ONE << 23;
    localparam logic [39:0] PCIN = ONE << 24,  MDRIN = ONE << 25,  IRIN = ONE << 26,     YIN = ONE << 27;
    localparam logic [39:0] LOIN = ONE << 28,  HIIN = ONE << 29,   GRA = ONE << 30,      GRB = ONE << 31;
    localparam logic [39:0] GRC = ONE << 32,   RIN = ONE << 33,    ROUT = ONE << 34,     COUT = ONE << 35;
    localparam logic [39:0] BAOUT = ONE << 36, CONIN = ONE << 37,  OPIN = ONE << 38,     OPOUT = ONE << 39;
    localparam logic [39:0] F0 = PCOUT | MARIN | INCPC | ZIN;

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] exp_seq [0:7];
    int          exp_len;
    bit          exp_halt_op;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push(input logic [39:0] m);
        exp_seq[exp_len] = m;
        exp_len++;
    endtask

    function automatic logic [39:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return ADDm;
            5'd4:        return SUBm;
            5'd5, 5'd13: return ANDm;
            5'd6, 5'd14: return ORm;
            5'd7:        return RORm;
            5'd8:        return ROLm;
            5'd9:        return SHRm;
            5'd10:       return SHRAm;
            5'd11:       return SHLm;
            default:     return '0;
        endcase
    endfunction

    // Step list of one instruction, fetch included, straight from the ISA description.
    task automatic model(input logic [4:0] op, input logic br);
        exp_len = 0;
        exp_halt_op = (op == 5'd27);
        push(F0); push(ZLOWOUT | PCIN | READ | MDRIN); push(MDROUT | IRIN);
        if (op >= 5'd3 && op <= 5'd14) begin
            push(GRB | ROUT | YIN);
            push(((op >= 5'd12) ? COUT : (GRC | ROUT)) | alu_of(op) | ZIN);
            push(ZLOWOUT | GRA | RIN);
        end else if (op <= 5'd2) begin
            push(GRB | BAOUT | YIN);
            push(COUT | ADDm | ZIN);
            if (op == 5'd1) push(ZLOWOUT | GRA | RIN);
            else            push(ZLOWOUT | MARIN);
            if (op == 5'd0) begin push(READ | MDRIN); push(MDROUT | GRA | RIN); end
            if (op == 5'd2) push(GRA | ROUT | WRITE);
        end else begin
            case (op)
                5'd15, 5'd16: begin
                    push(GRA | ROUT | YIN);
                    push(GRB | ROUT | ((op == 5'd16) ? MULm : DIVm) | ZIN);
                    push(ZLOWOUT | LOIN);
                    push(ZHIGHOUT | HIIN);
                end
                5'd17, 5'd18: begin
                    push(GRB | ROUT | ((op == 5'd17) ? NEGm : NOTm) | ZIN);
                    push(ZLOWOUT | GRA | RIN);
                end
                5'd19: begin
                    push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ADDm | ZIN);
                    push(br ? (ZLOWOUT | PCIN) : 40'd0);
                end
                5'd20: push(GRA | ROUT | PCIN);
                5'd21: begin push(PCOUT | GRB | RIN); push(GRA | ROUT | PCIN); end
                5'd22: push(OPOUT | GRA | RIN);
                5'd23: push(GRA | ROUT | OPIN);
                5'd24: push(HIOUT | GRA | RIN);
                5'd25: push(LOOUT | GRA | RIN);
                default: ;
            endcase
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clock);
        Clear = 1'b0; Stop = 1'b0;
        repeat (3) @(negedge Clock);
        check({tag, " reset held"}, {Run, Ctrl}, 41'd0);
        Clear = 1'b1;
        #1;
        check({tag, " reset released"}, {Run, Ctrl}, 41'd0);
        @(negedge Clock);
        check({tag, " first T0"}, {Run, Ctrl}, {1'b1, F0});
    endtask

    // Entered at a negedge with the unit in T0; leaves it in T0 again (or reset after a halt).
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic br,
                             input int stop_step, input int tbl_cycles);
        int  k;
        bit  done;
        bit  want_halt;
        logic [4:0] op;
        op = ir[31:27];
        model(op, br);
        want_halt = exp_halt_op || (stop_step >= 0 && stop_step < exp_len);
        IR = ir; BranchOut = br;
        k = 0; done = 0;
        while (!done) begin
            if (k == stop_step) Stop = 1'b1;
            if (k < exp_len) check($sformatf("%s T%0d", tag, k), {Run, Ctrl}, {1'b1, exp_seq[k]});
            @(negedge Clock);
            k++;
            if (Run !== 1'b1 || Ctrl === F0 || k >= 12) done = 1;
        end
        check({tag, " cycles"}, 41'(k), 41'(exp_len));
        if (tbl_cycles >= 0) check({tag, " table cycles"}, 41'(k), 41'(tbl_cycles));
        if (want_halt) begin
            check({tag, " halted"}, {Run, Ctrl}, 41'd0);
            @(negedge Clock);
            check({tag, " stays halted"}, {Run, Ctrl}, 41'd0);
            do_reset(tag);
        end else begin
            check({tag, " back to T0"}, {Run, Ctrl}, {1'b1, F0});
        end
        Stop = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        br;
        int          stop_step;
        int          cycles;
    } vec_t;

    function automatic logic [31:0] mk(input logic [4:0] op);
        return {op, 27'h2A5_1C3D};
    endfunction

    initial begin
        vec_t tbl[$];
        tbl.push_back('{"add",       32'h18910000, 1'b0, -1, 6});
        tbl.push_back('{"sub",       mk(5'd4),     1'b1, -1, 6});
        tbl.push_back('{"shra",      mk(5'd10),    1'b0, -1, 6});
        tbl.push_back('{"ld",        32'h00800005, 1'b0, -1, 8});
        tbl.push_back('{"ldi",       mk(5'd1),     1'b0, -1, 6});
        tbl.push_back('{"st",        mk(5'd2),     1'b0, -1, 7});
        tbl.push_back('{"addi",      mk(5'd12),    1'b0, -1, 6});
        tbl.push_back('{"ori",       mk(5'd14),    1'b0, -1, 6});
        tbl.push_back('{"mul",       mk(5'd16),    1'b0, -1, 7});
        tbl.push_back('{"div",       mk(5'd15),    1'b0, -1, 7});
        tbl.push_back('{"neg",       mk(5'd17),    1'b0, -1, 5});
        tbl.push_back('{"not",       mk(5'd18),    1'b0, -1, 5});
        tbl.push_back('{"br_taken",  mk(5'd19),    1'b1, -1, 7});
        tbl.push_back('{"br_not",    mk(5'd19),    1'b0, -1, 7});
        tbl.push_back('{"jr",        mk(5'd20),    1'b0, -1, 4});
        tbl.push_back('{"jal",       mk(5'd21),    1'b0, -1, 5});
        tbl.push_back('{"in",        mk(5'd22),    1'b0, -1, 4});
        tbl.push_back('{"out",       mk(5'd23),    1'b0, -1, 4});
        tbl.push_back('{"mfhi",      mk(5'd24),    1'b0, -1, 4});
        tbl.push_back('{"mflo",      mk(5'd25),    1'b0, -1, 4});
        tbl.push_back('{"nop",       mk(5'd26),    1'b0, -1, 3});
        tbl.push_back('{"undef",     mk(5'd31),    1'b0, -1, 3});
        tbl.push_back('{"add_stop",  32'h18910000, 1'b0,  4, 6});
        tbl.push_back('{"halt",      mk(5'd27),    1'b0, -1, 3});
        tbl.push_back('{"nop_stop",  mk(5'd26),    1'b0,  2, 3});

        // Reset held over several edges, then released.
        repeat (3) @(negedge Clock);
        check("reset Ctrl/Run", {Run, Ctrl}, 41'd0);
        Clear = 1'b1;
        #1;
        check("reset before edge", {Run, Ctrl}, 41'd0);
        @(negedge Clock);
        check("reset -> T0", {Run, Ctrl}, {1'b1, F0});

        foreach (tbl[i]) run_instr(tbl[i].name, tbl[i].ir, tbl[i].br, tbl[i].stop_step, tbl[i].cycles);

        // Clear dropped asynchronously at T5 of a load.
        IR = 32'h00800005;
        for (int k = 0; k < 5; k++) @(negedge Clock);
        check("ld T5 before clear", {Run, Ctrl}, {1'b1, ZLOWOUT | MARIN});
        #2 Clear = 1'b0;
        #1 check("clear mid-ld", {Run, Ctrl}, 41'd0);
        @(negedge Clock);
        check("clear mid-ld held", {Run, Ctrl}, 41'd0);
        Clear = 1'b1;
        @(negedge Clock);
        check("clear mid-ld -> T0", {Run, Ctrl}, {1'b1, F0});

        // Random instruction stream with occasional stop requests.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] rir;
            int          sstep;
            rir   = $urandom;
            sstep = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr($sformatf("rnd%0d op%0d", n, rir[31:27]), rir, 1'($urandom_range(0, 1)), sstep, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
